// File: rtl/rast_sample_merge_if.sv
// Sample-lane bundle: parallel lane samples in with an active-low halt back upstream,
// and a single-sample valid/ready stream out.
interface rast_sample_merge_if #(
    parameter int SIGFIG    = 24,
    parameter int AXIS      = 3,
    parameter int COLORS    = 3,
    parameter int NUM_LANES = 3
);
    logic signed [NUM_LANES-1:0][AXIS-1:0][SIGFIG-1:0]   hit_in_S;
    logic        [NUM_LANES-1:0][COLORS-1:0][SIGFIG-1:0] color_in_U;
    logic        [NUM_LANES-1:0]                         hit_valid_in_H;
    logic                                                halt_RnnnnL;
    logic signed [AXIS-1:0][SIGFIG-1:0]                  hit_out_S;
    logic        [COLORS-1:0][SIGFIG-1:0]                color_out_U;
    logic                                                hit_valid_out_H;
    logic                                                out_ready_H;

    modport master (
        output hit_in_S, color_in_U, hit_valid_in_H, out_ready_H,
        input  halt_RnnnnL, hit_out_S, color_out_U, hit_valid_out_H
    );

    modport slave (
        input  hit_in_S, color_in_U, hit_valid_in_H, out_ready_H,
        output halt_RnnnnL, hit_out_S, color_out_U, hit_valid_out_H
    );
endinterface

// File: rtl/rast_sample_merge.sv
// Compacts valid sample lanes into a circular FIFO and replays them one per cycle (valid/ready).
// Latency: 1 cycle push-to-output, FWFT head; no bypass when empty. Optional stats: RAST_MERGE_STATS_EN.
// Backpressure: halt_RnnnnL low once fewer than NUM_LANES slots remain; lanes beyond free space drop (sticky overflow).
module rast_sample_merge #(
    parameter int SIGFIG     = 24,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int NUM_LANES  = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rast_sample_merge_if.slave   smp,
    output logic                 overflow_H
`ifdef RAST_MERGE_STATS_EN
    ,
    output logic [31:0]          sample_count_U,
    output logic [15:0]          drop_count_U
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = AXIS * SIGFIG;
    localparam int CW = COLORS * SIGFIG;
    localparam logic [PW:0]   ONE     = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   HALT_TH = (PW+1)'(FIFO_DEPTH - NUM_LANES);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [HW-1:0] hit;
        logic [CW-1:0] color;
    } entry_t;

    entry_t              mem [FIFO_DEPTH];
    entry_t              head;
    entry_t              lane_ent [NUM_LANES];
    logic [PW-1:0]       wr_idx   [NUM_LANES];
    logic [NUM_LANES-1:0] accept;
    logic [PW:0]         count, free, k, ndrop;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic                pop;

    assign free = DEPTH_C - count;
    assign pop  = (count != '0) & smp.out_ready_H;

    // First 'free' valid lanes win, packed densely from wr_ptr in lane order.
    always_comb begin
        k      = '0;
        ndrop  = '0;
        accept = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_ent[i] = '{hit: smp.hit_in_S[i], color: smp.color_in_U[i]};
            wr_idx[i]   = wr_ptr + k[PW-1:0];
            if (smp.hit_valid_in_H[i]) begin
                if (k < free) begin
                    accept[i] = 1'b1;
                    k         = k + ONE;
                end else begin
                    ndrop = ndrop + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_H <= 1'b0;
        end else begin
            count  <= count + k - {{PW{1'b0}}, pop};
            wr_ptr <= wr_ptr + k[PW-1:0];
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (ndrop != '0)
                overflow_H <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (accept[i])
                mem[wr_idx[i]] <= lane_ent[i];
        end
    end

    // Outputs decode from registered state only; accepted writes never land on the live head.
    assign head                = mem[rd_ptr];
    assign smp.hit_valid_out_H = (count != '0);
    assign smp.hit_out_S       = (count != '0) ? head.hit   : '0;
    assign smp.color_out_U     = (count != '0) ? head.color : '0;
    assign smp.halt_RnnnnL     = ~(count > HALT_TH);

`ifdef RAST_MERGE_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_count_U} + 17'(ndrop);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count_U <= '0;
            drop_count_U   <= '0;
        end else begin
            if (pop)
                sample_count_U <= sample_count_U + 32'd1;
            drop_count_U <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif
endmodule
